uart_link: RTL and testbench

UART_LINK -- requirements
Module: uart_link

---
 rtl/uart_link_pkg.sv | 29 ++
 rtl/uart_link_rx.sv | 132 +++++++++++++
 rtl/uart_link.sv | 135 +++++++++++++
 tb/tb_uart_link.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_link_pkg.sv
// uart_link_pkg -- shared types, counter widths and parity helper for uart_link.
// Build option: define UART_LINK_PARITY_EN to add the PARITY state to both FSMs.
package uart_link_pkg;

  localparam int MAX_CLKS_PER_PULSE = 65535;
  localparam int MAX_BITS_PER_WORD  = 9;

  // Counters are sized for the largest legal parameters; both only ever
  // count up to a parameter minus one, so they never wrap by overflow.
  localparam int CLK_CNT_W = $clog2(MAX_CLKS_PER_PULSE);
  localparam int BIT_CNT_W = $clog2(MAX_BITS_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_LINK_PARITY_EN
    PARITY,
`endif
    STOP
  } uart_state_e;

  // Even parity of the (zero-extended) word, inverted for odd sense.
  function automatic logic calc_parity(input logic [MAX_BITS_PER_WORD-1:0] d,
                                       input logic                         odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_link_rx.sv
// uart_link_rx -- UART receiver with mid-bit sampling and one-deep output hold.
// Ports: clk, rstn (async low), rx (serial in), m_data/m_valid/m_ready (word
// stream out), frame_err/parity_err/overrun (single-cycle pulses).
// Build option: UART_LINK_PARITY_EN enables the parity check.
module uart_link_rx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD  = 8,
  parameter int PARITY_ODD     = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun
);

  logic [1:0]               sync_q;
  logic                     rx_s;
  logic                     rx_prev;
  uart_state_e              state;
  logic [CLK_CNT_W-1:0]     cnt;
  logic [BIT_CNT_W-1:0]     bit_idx;
  logic [BITS_PER_WORD-1:0] sh;
  logic                     cnt_last;
  logic                     cnt_half;

  assign rx_s     = sync_q[1];
  assign cnt_last = (cnt == CLK_CNT_W'(CLKS_PER_PULSE - 1));
  assign cnt_half = (cnt == CLK_CNT_W'(CLKS_PER_PULSE / 2 - 1));

  // Line idles high, so the synchroniser and edge detector reset to 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q  <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], rx};
      rx_prev <= rx_s;
    end
  end

`ifdef UART_LINK_PARITY_EN
  logic par_bad;
`else
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      sh        <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_LINK_PARITY_EN
      parity_err <= 1'b0;
      par_bad    <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_LINK_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (m_valid && m_ready) m_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          // Needs a high-to-low transition, so after a frame error the
          // line must return high before another start is accepted.
          if (rx_prev && !rx_s) state <= START;
        end
        START: begin
          if (cnt_half) begin
            cnt   <= '0;
            state <= rx_s ? IDLE : DATA;  // high at mid-start = glitch
          end else cnt <= cnt + CLK_CNT_W'(1);
        end
        DATA: begin
          if (cnt_last) begin
            cnt <= '0;
            sh  <= {rx_s, sh[BITS_PER_WORD-1:1]};  // LSB arrives first
            if (bit_idx == BIT_CNT_W'(BITS_PER_WORD - 1)) begin
              bit_idx <= '0;
`ifdef UART_LINK_PARITY_EN
              state   <= PARITY;
`else
              state   <= STOP;
`endif
            end else bit_idx <= bit_idx + BIT_CNT_W'(1);
          end else cnt <= cnt + CLK_CNT_W'(1);
        end
`ifdef UART_LINK_PARITY_EN
        PARITY: begin
          if (cnt_last) begin
            cnt     <= '0;
            par_bad <= rx_s ^ calc_parity(MAX_BITS_PER_WORD'(sh), PARITY_ODD != 0);
            state   <= STOP;
          end else cnt <= cnt + CLK_CNT_W'(1);
        end
`endif
        STOP: begin
          if (cnt_last) begin
            cnt   <= '0;
            state <= IDLE;
            if (!rx_s) frame_err <= 1'b1;
`ifdef UART_LINK_PARITY_EN
            else if (par_bad) parity_err <= 1'b1;
`endif
            else if (m_valid && !m_ready) overrun <= 1'b1;  // keep old word
            else begin
              m_data  <= sh;
              m_valid <= 1'b1;
            end
          end else cnt <= cnt + CLK_CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_link.sv
// uart_link -- full-duplex UART: inline TX FSM plus uart_link_rx receiver.
// Ports: clk, rstn (async low), rx/tx serial lines, s_data/s_valid/s_ready TX
// word stream in, m_data/m_valid/m_ready RX word stream out, frame_err,
// parity_err, overrun single-cycle error pulses.
// Build option: define UART_LINK_PARITY_EN to add a parity bit (PARITY_ODD
// selects odd sense); otherwise parity_err is tied low.
module uart_link
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD  = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_ODD     = 0
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  output logic                     tx,
  input  logic [BITS_PER_WORD-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     frame_err,
  output logic                     parity_err,
  output logic                     overrun
);

  uart_state_e              tx_state;
  logic [CLK_CNT_W-1:0]     tx_cnt;
  logic [BIT_CNT_W-1:0]     tx_bit;
  logic [BITS_PER_WORD-1:0] tx_sh;
  logic                     tx_last;

  assign tx_last = (tx_cnt == CLK_CNT_W'(CLKS_PER_PULSE - 1));

`ifdef UART_LINK_PARITY_EN
  logic tx_par;
`endif

  // tx is a register with async reset, so it snaps high the instant rstn
  // falls. s_ready is registered and only ever high while in IDLE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= IDLE;
      tx       <= 1'b1;
      s_ready  <= 1'b0;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
`ifdef UART_LINK_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      case (tx_state)
        IDLE: begin
          if (s_valid && s_ready) begin
            tx_state <= START;
            tx       <= 1'b0;
            s_ready  <= 1'b0;
            tx_sh    <= s_data;
`ifdef UART_LINK_PARITY_EN
            tx_par   <= calc_parity(MAX_BITS_PER_WORD'(s_data), PARITY_ODD != 0);
`endif
          end else s_ready <= 1'b1;
        end
        START: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_state <= DATA;
            tx       <= tx_sh[0];
            tx_sh    <= tx_sh >> 1;
          end else tx_cnt <= tx_cnt + CLK_CNT_W'(1);
        end
        DATA: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_CNT_W'(BITS_PER_WORD - 1)) begin
              tx_bit   <= '0;
`ifdef UART_LINK_PARITY_EN
              tx_state <= PARITY;
              tx       <= tx_par;
`else
              tx_state <= STOP;
              tx       <= 1'b1;
`endif
            end else begin
              tx_bit <= tx_bit + BIT_CNT_W'(1);
              tx     <= tx_sh[0];
              tx_sh  <= tx_sh >> 1;
            end
          end else tx_cnt <= tx_cnt + CLK_CNT_W'(1);
        end
`ifdef UART_LINK_PARITY_EN
        PARITY: begin
          if (tx_last) begin
            tx_cnt   <= '0;
            tx_state <= STOP;
            tx       <= 1'b1;
          end else tx_cnt <= tx_cnt + CLK_CNT_W'(1);
        end
`endif
        STOP: begin
          if (tx_last) begin
            tx_cnt <= '0;
            if (tx_bit == BIT_CNT_W'(STOP_BITS - 1)) begin
              tx_bit   <= '0;
              tx_state <= IDLE;
              s_ready  <= 1'b1;  // ready in the single idle cycle between words
            end else tx_bit <= tx_bit + BIT_CNT_W'(1);
          end else tx_cnt <= tx_cnt + CLK_CNT_W'(1);
        end
        default: tx_state <= IDLE;
      endcase
    end
  end

  uart_link_rx #(
    .CLKS_PER_PULSE(CLKS_PER_PULSE),
    .BITS_PER_WORD (BITS_PER_WORD),
    .PARITY_ODD    (PARITY_ODD)
  ) u_rx (
    .clk       (clk),
    .rstn      (rstn),
    .rx        (rx),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link -- randomized scoreboard bench for uart_link (C=4, 8N1).
module tb_uart_link;
  localparam int C     = 4;
  localparam int N     = 8;
  localparam int NSTOP = 1;
`ifdef UART_LINK_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FB = 1 + N + PAR_EN + NSTOP;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rstn, rx, tx, rx_drv, loop_en;
  logic [N-1:0] s_data, m_data;
  logic s_valid, s_ready, m_valid, m_ready, frame_err, parity_err, overrun;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk = ~clk;

  uart_link #(.CLKS_PER_PULSE(C), .BITS_PER_WORD(N), .STOP_BITS(NSTOP), .PARITY_ODD(0)) dut (
    .clk(clk), .rstn(rstn), .rx(rx), .tx(tx),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun));

  int n_chk = 0, n_pass = 0;
  int fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int fe_exp = 0, pe_exp = 0, ov_exp = 0;
  logic [N-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
  endtask

  // Reference serial frame: start 0, data LSB first, even parity (number of
  // ones made even), then stop bits of 1. Flags corrupt parity / first stop.
  function automatic bitq_t frame_bits(input logic [N-1:0] d, input bit bad_par, input bit bad_stop);
    bitq_t q;
    int ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < N; i++) begin
      q.push_back(((d >> i) & 1) != 0);
      ones += int'((d >> i) & 1);
    end
    if (PAR_EN != 0) q.push_back(((ones % 2) == 1) ^ bad_par);
    for (int i = 0; i < NSTOP; i++) q.push_back(!(bad_stop && i == 0));
    return q;
  endfunction

  // Monitor: error pulse counting and scoreboard pop on each accepted word.
  always @(negedge clk) begin
    if (rstn) begin
      if (frame_err)  fe_cnt++;
      if (parity_err) pe_cnt++;
      if (overrun)    ov_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL rx_unexpected got=%0h expected=none", m_data);
        end else check("rx_word", 32'(m_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic send_word(input logic [N-1:0] d, input bit check_wave);
    int t = 0;
    bitq_t q;
    while (!s_ready && t < 1000) begin @(negedge clk); t++; end
    if (!s_ready) begin
      n_chk++;
      $display("FAIL send_timeout got=s_ready 0 expected=1");
      return;
    end
    s_data = d; s_valid = 1'b1;
    @(posedge clk); #1 s_valid = 1'b0;
    if (check_wave) begin
      q = frame_bits(d, 1'b0, 1'b0);
      for (int k = 0; k < FB * C; k++) begin
        @(negedge clk);
        check("tx_bit", 32'(tx), 32'(q[k / C]));
        check("s_ready_busy", 32'(s_ready), 0);
      end
      @(negedge clk);
      check("s_ready_done", 32'(s_ready), 1);
    end
  endtask

  task automatic drive_frame(input logic [N-1:0] d, input bit bad_par, input bit bad_stop);
    bitq_t q = frame_bits(d, bad_par, bad_stop);
    foreach (q[i]) begin
      rx_drv = q[i];
      repeat (C) @(negedge clk);
    end
    rx_drv = 1'b1;
    repeat (4 * C) @(negedge clk);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 2000) begin @(negedge clk); t++; end
    check("drain_left", 32'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] d;
    int e;
    rstn = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 1);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_errs", {29'd0, frame_err, parity_err, overrun}, 0);
    rstn = 1'b1;
    #1 check("s_ready_pre", 32'(s_ready), 0);
    @(posedge clk); #1 check("s_ready_first", 32'(s_ready), 1);

    // Reset mid-frame: tx returns high in the same cycle.
    send_word(8'h00, 1'b0);
    repeat (8) @(negedge clk);
    check("mid_tx_low", 32'(tx), 0);
    rstn = 1'b0;
    #1 check("mid_rst_tx", 32'(tx), 1);
    check("mid_rst_s_ready", 32'(s_ready), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1 check("s_ready_after_rst", 32'(s_ready), 1);

    // Directed waveform and loopback words.
    loop_en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'hA5); send_word(8'hA5, 1'b1);
    exp_q.push_back(8'h3C); send_word(8'h3C, 1'b0);
    wait_drain();
    for (int i = 0; i < 16; i++) begin
      d = N'($urandom);
      exp_q.push_back(d);
      send_word(d, 1'b0);
    end
    wait_drain();
    check("loop_no_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 0);

    // Framing error on a driven frame.
    loop_en = 1'b0;
    @(negedge clk);
    drive_frame(8'h55, 1'b0, 1'b1); fe_exp++;
    check("frame_err_cnt", 32'(fe_cnt), 32'(fe_exp));
    check("frame_m_valid", 32'(m_valid), 0);

    // Overrun: second word dropped while first is held.
    m_ready = 1'b0;
    exp_q.push_back(8'h11);
    drive_frame(8'h11, 1'b0, 1'b0);
    drive_frame(8'h22, 1'b0, 1'b0); ov_exp++;
    check("ovr_m_valid", 32'(m_valid), 1);
    check("ovr_m_data", 32'(m_data), 32'h11);
    check("ovr_cnt", 32'(ov_cnt), 32'(ov_exp));
    m_ready = 1'b1;
    wait_drain();

    // One-cycle glitch is ignored; next frame still received.
    rx_drv = 1'b0; @(negedge clk);
    rx_drv = 1'b1; repeat (20) @(negedge clk);
    check("glitch_m_valid", 32'(m_valid), 0);
    check("glitch_errs", 32'(fe_cnt + pe_cnt + ov_cnt), 32'(fe_exp + pe_exp + ov_exp));
    exp_q.push_back(8'h81);
    drive_frame(8'h81, 1'b0, 1'b0);
    wait_drain();

`ifdef UART_LINK_PARITY_EN
    loop_en = 1'b1;
    @(negedge clk);
    exp_q.push_back(8'h07); send_word(8'h07, 1'b1);
    wait_drain();
    loop_en = 1'b0;
    @(negedge clk);
    drive_frame(8'h07, 1'b1, 1'b0); pe_exp++;
    check("parity_err_cnt", 32'(pe_cnt), 32'(pe_exp));
    check("parity_m_valid", 32'(m_valid), 0);
`endif

    // Random driven frames with random corruption.
    for (int i = 0; i < 12; i++) begin
      d = N'($urandom);
      e = int'($urandom_range(0, 1 + PAR_EN));
      if (e == 0) exp_q.push_back(d);
      else if (e == 1) fe_exp++;
      else pe_exp++;
      drive_frame(d, e == 2, e == 1);
    end
    wait_drain();

    check("final_fe", 32'(fe_cnt), 32'(fe_exp));
    check("final_pe", 32'(pe_cnt), 32'(pe_exp));
    check("final_ov", 32'(ov_cnt), 32'(ov_exp));
    check("final_m_valid", 32'(m_valid), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
